// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, SRAM geometry
// and the latched request bundle.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone requester wins, a tie goes to the
// port that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = req[1];
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared 1Mx16
// asynchronous SRAM: latches one request, strobes for WAIT_CYCLES, then acks.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              grant,
    output logic              busy,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Mem_Dout,
    output logic              Mem_Dout_en,
    input  logic [DATA_W-1:0] Mem_Din
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    arb_state_t state, next_state;
    sram_req_t  cur_req, sel_req;
    logic [3:0] wait_cnt;
    logic       last_grant, gnt_valid, gnt_id;
    logic       load, next_we, next_access;

    rr_arb2 u_rr_arb2 (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        sel_req.we    = gnt_id ? we1 : we0;
        sel_req.addr  = gnt_id ? SRAM_ADDR_W'(addr1) : SRAM_ADDR_W'(addr0);
        sel_req.wdata = gnt_id ? SRAM_DATA_W'(wdata1) : SRAM_DATA_W'(wdata0);
        next_state    = state;
        load          = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    next_state = ACCESS;
                    load       = 1'b1;
                end
            end
            ACCESS:  if (wait_cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        next_we     = load ? sel_req.we : cur_req.we;
        next_access = (next_state == ACCESS);
    end

    // NOTE: strobes and ack are registered from the next state, so the pads only ever see flop outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cur_req     <= '0;
            wait_cnt    <= '0;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            rdata       <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            Mem_CE      <= 1'b1;
            Mem_UB      <= 1'b1;
            Mem_LB      <= 1'b1;
            Mem_OE      <= 1'b1;
            Mem_WE      <= 1'b1;
            Mem_Dout_en <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                cur_req    <= sel_req;
                wait_cnt   <= WAIT_LOAD;
                last_grant <= gnt_id;
                grant      <= gnt_id;
            end else if (state == ACCESS && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // The last strobe cycle is the only one where read data is guaranteed settled.
            if (state == ACCESS && wait_cnt == '0 && !cur_req.we) begin
                rdata <= Mem_Din;
            end
            ack0        <= (next_state == DONE) && !grant;
            ack1        <= (next_state == DONE) && grant;
            Mem_CE      <= !next_access;
            Mem_UB      <= !next_access;
            Mem_LB      <= !next_access;
            Mem_OE      <= !(next_access && !next_we);
            Mem_WE      <= !(next_access && next_we);
            Mem_Dout_en <= next_access && next_we;
        end
    end

    assign busy     = (state != IDLE);
    assign Mem_ADDR = ADDR_W'(cur_req.addr);
    assign Mem_Dout = DATA_W'(cur_req.wdata);

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised scoreboard bench for sram_arbiter: per-port expectation queues,
// a behavioural SRAM and a reference memory, plus a WAIT_CYCLES=1 instance.
module tb_sram_arbiter;

    localparam int W = 2;

    typedef struct {
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        int          issue;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0, req1, we0, we1;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, grant, busy;
    logic [15:0] rdata;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Dout_en;
    logic [19:0] Mem_ADDR;
    logic [15:0] Mem_Dout;
    logic [15:0] mem_din;

    logic        w1_req, w1_we;
    logic [19:0] w1_addr;
    logic [15:0] w1_wdata;
    logic        w1_ack0, w1_ack1, w1_grant, w1_busy;
    logic [15:0] w1_rdata;
    logic        w1_ce, w1_ub, w1_lb, w1_oe, w1_we_n, w1_den;
    logic [19:0] w1_maddr;
    logic [15:0] w1_mdout;
    logic [15:0] w1_din;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    bit          served_log[$];
    logic [15:0] sram    [logic [19:0]];
    logic [15:0] ref_mem [logic [19:0]];
    logic [15:0] lr_exp;
    int          strobe_cnt;
    bit          seen_we;
    logic [19:0] seen_addr;
    logic [15:0] seen_dout;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .grant(grant), .busy(busy),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_ADDR(Mem_ADDR), .Mem_Dout(Mem_Dout), .Mem_Dout_en(Mem_Dout_en), .Mem_Din(mem_din)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .req0(w1_req), .req1(1'b0), .we0(w1_we), .we1(1'b0),
        .addr0(w1_addr), .addr1(20'h0), .wdata0(w1_wdata), .wdata1(16'h0),
        .ack0(w1_ack0), .ack1(w1_ack1), .rdata(w1_rdata), .grant(w1_grant), .busy(w1_busy),
        .Mem_CE(w1_ce), .Mem_UB(w1_ub), .Mem_LB(w1_lb), .Mem_OE(w1_oe), .Mem_WE(w1_we_n),
        .Mem_ADDR(w1_maddr), .Mem_Dout(w1_mdout), .Mem_Dout_en(w1_den), .Mem_Din(w1_din)
    );

    assign w1_din = w1_maddr[15:0] ^ 16'hC0DE;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] init_val(input logic [19:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_read(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural asynchronous SRAM
    always @(negedge Clk) begin
        if (!Mem_CE && !Mem_WE && Mem_Dout_en) sram[Mem_ADDR] = Mem_Dout;
        mem_din <= sram.exists(Mem_ADDR) ? sram[Mem_ADDR] : init_val(Mem_ADDR);
    end

    // Monitor: pops the expectation of the acknowledged port and compares
    always @(negedge Clk) begin : monitor
        exp_t e;
        bit   p;
        int   sz;
        if (Reset) begin
            strobe_cnt = 0;
            lr_exp     = '0;
        end else begin
            if (!Mem_CE && (!Mem_WE || !Mem_OE)) begin
                strobe_cnt++;
                seen_we   = !Mem_WE;
                seen_addr = Mem_ADDR;
                seen_dout = Mem_Dout;
                check("dout_en_only_on_write", Mem_Dout_en, !Mem_WE);
            end
            if (ack0 || ack1) begin
                p  = ack1;
                sz = p ? q1.size() : q0.size();
                check("single_ack", ack0 & ack1, 0);
                check("grant_matches_ack", grant, p);
                check("done_strobes_idle", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Dout_en}, 6'b111110);
                check("busy_in_done", busy, 1);
                check("ack_has_request", sz != 0, 1);
                if (sz != 0) begin
                    e = p ? q1.pop_front() : q0.pop_front();
                    check("access_kind", seen_we, e.we);
                    check("strobe_len", strobe_cnt, W);
                    check("mem_addr", seen_addr, e.addr);
                    if (e.we) begin
                        check("mem_dout", seen_dout, e.wdata);
                        check("rdata_hold_on_write", rdata, lr_exp);
                    end else begin
                        check("rdata", rdata, e.rdata);
                        lr_exp = e.rdata;
                    end
                    if (e.lat >= 0) check("ack_latency", cyc - e.issue, e.lat);
                end
                served_log.push_back(p);
                strobe_cnt = 0;
            end
        end
    end

    task automatic set_port(input bit p, input bit r, input bit w, input logic [19:0] a, input logic [15:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Called and returns aligned to 1 time unit after a rising edge.
    task automatic do_access(input bit p, input bit we, input logic [19:0] a, input logic [15:0] d,
                             input int lat, input bit scr);
        exp_t e;
        bit   got, scrd;
        e.we = we; e.addr = a; e.wdata = d; e.lat = lat; e.issue = cyc;
        e.rdata = ref_read(a);
        if (we) ref_mem[a] = d;
        if (p) q1.push_back(e); else q0.push_back(e);
        set_port(p, 1'b1, we, a, d);
        got = 0; scrd = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge Clk);
            if (scr && !scrd && busy && grant == p) begin
                set_port(p, 1'b1, ~we, ~a, ~d);
                scrd = 1;
            end
            if (p ? ack1 : ack0) got = 1;
        end
        check(p ? "ack1_timeout" : "ack0_timeout", got, 1);
        @(posedge Clk);
        #1;
        set_port(p, 1'b0, we, a, d);
    endtask

    task automatic w1_access(input bit we, input logic [19:0] a, input logic [15:0] d);
        int          t0, sc, lat;
        bit          got;
        logic [19:0] sa;
        logic [15:0] sd;
        w1_we = we; w1_addr = a; w1_wdata = d; w1_req = 1'b1;
        t0 = cyc; sc = 0; lat = -1; got = 0; sa = '0; sd = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clk);
            if (!w1_ce && (!w1_oe || !w1_we_n)) begin
                sc++; sa = w1_maddr; sd = w1_mdout;
            end
            if (i == 1) begin
                w1_we = ~we; w1_addr = ~a; w1_wdata = ~d;
            end
            if (w1_ack0) begin
                got = 1; lat = cyc - t0;
                check("w1_ack1_quiet", w1_ack1, 0);
            end
        end
        @(posedge Clk);
        #1;
        w1_req = 1'b0;
        check("w1_ack_seen", got, 1);
        check("w1_latency", lat, 2);
        check("w1_strobe_len", sc, 1);
        check("w1_addr_latched", sa, a);
        if (we) check("w1_dout_latched", sd, d);
        else    check("w1_rdata", w1_rdata, a[15:0] ^ 16'hC0DE);
    endtask

    initial begin
        Reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        w1_req = 0; w1_we = 0; w1_addr = '0; w1_wdata = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_strobes", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}, 5'b11111);
        check("rst_dout_en", Mem_Dout_en, 0);
        check("rst_mem_addr", Mem_ADDR, 0);
        check("rst_mem_dout", Mem_Dout, 0);
        check("rst_rdata", rdata, 0);
        check("rst_acks", {ack0, ack1}, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Port-0 write with inputs scrambled after the grant, then port-1 read-back
        do_access(0, 1, 20'h00012, 16'hBEEF, W + 1, 1);
        do_access(1, 0, 20'h00012, 16'h0000, W + 1, 0);

        // Simultaneous requests right after reset: port 0 first, then strict alternation
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        served_log.delete();
        fork
            for (int i = 0; i < 2; i++) do_access(0, 1'($urandom_range(0, 1)), 20'(20'h00200 + i), 16'($urandom), -1, 0);
            for (int j = 0; j < 2; j++) do_access(1, 1'($urandom_range(0, 1)), 20'(20'h80200 + j), 16'($urandom), -1, 0);
        join
        check("tie_served_count", served_log.size(), 4);
        for (int k = 0; k < served_log.size(); k++) check("tie_order", served_log[k], k % 2);

        // Reset in the second strobe cycle of a write
        we0 = 1; addr0 = 20'h40000; wdata0 = 16'h1234; req0 = 1;
        @(posedge Clk);
        #1;
        check("abort_we_low", Mem_WE, 0);
        @(posedge Clk);
        #1;
        check("abort_busy_before", busy, 1);
        Reset = 1'b1;
        #1;
        check("abort_we_async", Mem_WE, 1);
        check("abort_ce_async", Mem_CE, 1);
        check("abort_dout_en_async", Mem_Dout_en, 0);
        req0 = 0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("abort_idle", busy, 0);
        check("abort_no_ack", {ack0, ack1}, 2'b00);

        // Randomised traffic from both ports on disjoint address windows
        fork
            begin : port0_traffic
                int g;
                for (int i = 0; i < 25; i++) begin
                    g = $urandom_range(0, 3);
                    if (g > 0) begin
                        repeat (g) @(posedge Clk);
                        #1;
                    end
                    do_access(0, 1'($urandom_range(0, 1)), 20'(20'h00100 + $urandom_range(0, 7)), 16'($urandom), -1, 1);
                end
            end
            begin : port1_traffic
                int g;
                for (int j = 0; j < 25; j++) begin
                    g = $urandom_range(0, 3);
                    if (g > 0) begin
                        repeat (g) @(posedge Clk);
                        #1;
                    end
                    do_access(1, 1'($urandom_range(0, 1)), 20'(20'h80100 + $urandom_range(0, 7)), 16'($urandom), -1, 1);
                end
            end
        join
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        // WAIT_CYCLES=1 instance: single strobe cycle, ack two cycles after req
        w1_access(1, 20'h00034, 16'hA5A5);
        w1_access(0, 20'h00077, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
